axi4_frame_reader: RTL and testbench

- AXI4 read master, memory-mapped to stream; the read-side counterpart of the DDR frame-buffer writer.
- Fetches one 320x240 RGB565 frame from PS DDR in 640-byte INCR bursts and buffers it in an internal single-clock FIFO.
- Unpacks each 64-bit beat into four 16-bit pixels on a valid/ready stream toward the HDMI timing/output path.

---
 rtl/axi4_frame_reader.sv | 191 +++++++++++++++++++
 tb/tb_axi4_frame_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_reader.sv
`timescale 1ns/1ps
// AXI4 read master that fetches one RGB565 frame from DDR in fixed INCR bursts,
// buffers the beats in a single-clock FIFO and streams them out as 16-bit pixels.
module axi4_frame_reader #(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int BURST_BEATS      = 80,
    parameter int BURSTS_PER_FRAME = 240,
    parameter int FIFO_DEPTH       = 256
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      RLAST,
    input  logic [1:0]                RRESP,
    output logic [15:0]               pixel_data,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      reader_done,
    output logic                      rd_error,
    output logic [1:0]                state
);

    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W      = $clog2(BURST_BEATS);
    localparam int BURST_W     = $clog2(BURSTS_PER_FRAME + 1);
    localparam int BURST_BYTES = BURST_BEATS * (AXI_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_SEND = 2'd1,
        DATA_RECV = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic                      frame_start_q;
    logic                      frame_active;
    logic [AXI_ADDR_WIDTH-1:0] base_addr;
    logic [AXI_ADDR_WIDTH-1:0] offset;
    logic [BURST_W-1:0]        burst_cnt;
    logic [BEAT_W-1:0]         beat_cnt;

    logic [AXI_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          fifo_count;
    logic [1:0]                lane;
    logic [AXI_DATA_WIDTH-1:0] head_word;

    logic start_accept, r_hs, last_beat, frame_last;
    logic fifo_full, fifo_room, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_accept = frame_start && !frame_start_q && !frame_active && (cur_state == IDLE);
    assign r_hs         = RVALID && RREADY;
    assign last_beat    = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
    assign frame_last   = (burst_cnt == BURST_W'(BURSTS_PER_FRAME - 1));
    assign fifo_full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    // Space for a whole burst is reserved before the address goes out, so R never stalls.
    assign fifo_room    = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(BURST_BEATS);
    assign push         = r_hs && !fifo_full;
    assign pop          = pixel_valid && pixel_ready && (lane == 2'd3);

    assign ARADDR  = base_addr + offset;
    assign ARLEN   = 8'(BURST_BEATS - 1);
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b0011;
    assign ARPROT  = 3'b000;
    assign state   = cur_state;

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) cur_state <= IDLE;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:      if (frame_active && fifo_room) nxt_state = ADDR_SEND;
            ADDR_SEND: if (ARREADY) nxt_state = DATA_RECV;
            DATA_RECV: if (r_hs && last_beat) nxt_state = frame_last ? DONE : IDLE;
            DONE:      nxt_state = IDLE;
            default:   nxt_state = IDLE;
        endcase
    end

    always_comb begin
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        reader_done = 1'b0;
        case (cur_state)
            ADDR_SEND: ARVALID     = 1'b1;
            DATA_RECV: RREADY      = 1'b1;
            DONE:      reader_done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
            frame_active  <= 1'b0;
            base_addr     <= '0;
            offset        <= '0;
            burst_cnt     <= '0;
            beat_cnt      <= '0;
        end else begin
            frame_start_q <= frame_start;
            if (start_accept) begin
                base_addr    <= FRAME_BASE_ADDR;
                offset       <= '0;
                burst_cnt    <= '0;
                frame_active <= 1'b1;
            end
            // Bursts are delimited by beat count, not RLAST, so a bad RLAST cannot desync us.
            if (r_hs) begin
                if (last_beat) begin
                    beat_cnt  <= '0;
                    offset    <= offset + AXI_ADDR_WIDTH'(BURST_BYTES);
                    burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    beat_cnt  <= beat_cnt + 1'b1;
                end
            end
            if (cur_state == DONE) frame_active <= 1'b0;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n)
            rd_error <= 1'b0;
        else if (start_accept)
            rd_error <= 1'b0;
        else if (r_hs && ((RRESP != 2'b00) || (RLAST != last_beat) || fifo_full))
            rd_error <= 1'b1;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (push) fifo_mem[wr_ptr] <= RDATA;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            lane       <= 2'd0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (pixel_valid && pixel_ready) lane <= lane + 2'd1;
        end
    end

    assign pixel_valid = (fifo_count != '0);
    assign head_word   = fifo_mem[rd_ptr];

    always_comb begin
        pixel_data = head_word[63:48];
        case (lane)
            2'd1:    pixel_data = head_word[47:32];
            2'd2:    pixel_data = head_word[31:16];
            2'd3:    pixel_data = head_word[15:0];
            default: pixel_data = head_word[63:48];
        endcase
    end

endmodule

// File: tb/tb_axi4_frame_reader.sv
`timescale 1ns/1ps
// Directed bench for axi4_frame_reader: an AXI read slave backed by a DDR data
// model, a pixel sink with an address-derived scoreboard, and a linear test sequence.
module tb_axi4_frame_reader;

    // Shortened frame keeps the full-frame run reasonable; every other parameter is default.
    localparam int TB_BURSTS = 24;
    localparam int BEATS     = 80;
    localparam int PIX_BURST = 320;
    localparam int FRAME_PIX = TB_BURSTS * PIX_BURST;

    logic        clk_100Mhz = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] FRAME_BASE_ADDR;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        reader_done;
    logic        rd_error;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [31:0] ar_log [$];
    logic [7:0]  len_log [$];

    bit          slv_active = 1'b0;
    logic [31:0] slv_addr = '0;
    int          slv_beat = 0;
    int          cur_rresp_beat = -1;
    int          cur_rlast_beat = BEATS - 1;
    int          arm_rresp_beat = -1;
    int          arm_rlast_beat = -1;
    int          ar_stall_left = 0;
    bit          ar_fire = 1'b0;
    bit          r_fire = 1'b0;
    logic [31:0] ar_addr_hold = '0;
    bit          toggle_rvalid = 1'b0;
    bit          override_en = 1'b0;
    logic [63:0] override_data = '0;

    bit          check_pixels = 1'b0;
    logic [31:0] pix_base = '0;
    int          pix_idx = 0;
    int          done_count = 0;

    logic [15:0] order_exp [4];

    axi4_frame_reader #(.BURSTS_PER_FRAME(TB_BURSTS)) dut (
        .clk_100Mhz      (clk_100Mhz),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
        .ARADDR          (ARADDR),
        .ARVALID         (ARVALID),
        .ARREADY         (ARREADY),
        .ARLEN           (ARLEN),
        .ARSIZE          (ARSIZE),
        .ARBURST         (ARBURST),
        .ARCACHE         (ARCACHE),
        .ARPROT          (ARPROT),
        .RDATA           (RDATA),
        .RVALID          (RVALID),
        .RREADY          (RREADY),
        .RLAST           (RLAST),
        .RRESP           (RRESP),
        .pixel_data      (pixel_data),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .reader_done     (reader_done),
        .rd_error        (rd_error),
        .state           (state)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    // DDR contents: every 64-bit word is derived from its own byte address.
    function automatic logic [63:0] ddr_word(input logic [31:0] a);
        return {a, a ^ 32'h5A5A_C3C3};
    endfunction

    function automatic logic [15:0] exp_pixel(input logic [31:0] base, input int n);
        logic [63:0] w;
        w = ddr_word(base + 32'((n / 4) * 8));
        case (n % 4)
            0:       return w[63:48];
            1:       return w[47:32];
            2:       return w[31:16];
            default: return w[15:0];
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] base);
        FRAME_BASE_ADDR = base;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        pix_idx = 0;
    endtask

    // AXI read slave: decides its drive for the next edge one step after each edge.
    initial begin : axi_slave
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = '0;
        RLAST   = 1'b0;
        RRESP   = 2'b00;
        forever begin
            @(posedge clk_100Mhz);
            #1;
            if (rst_n !== 1'b1) begin
                slv_active = 1'b0;
                slv_beat   = 0;
                ar_fire    = 1'b0;
                r_fire     = 1'b0;
                ARREADY    = 1'b0;
                RVALID     = toggle_rvalid ? ~RVALID : 1'b0;
                RLAST      = 1'b0;
                RRESP      = 2'b00;
            end else begin
                if (r_fire) begin
                    slv_beat++;
                    if (slv_beat == BEATS) slv_active = 1'b0;
                end
                if (ar_fire) begin
                    slv_active     = 1'b1;
                    slv_addr       = ar_addr_hold;
                    slv_beat       = 0;
                    cur_rresp_beat = arm_rresp_beat;
                    cur_rlast_beat = (arm_rlast_beat >= 0) ? arm_rlast_beat : BEATS - 1;
                    arm_rresp_beat = -1;
                    arm_rlast_beat = -1;
                end
                if (ARVALID && ar_stall_left > 0) begin
                    ARREADY = 1'b0;
                    ar_stall_left--;
                end else begin
                    ARREADY = 1'b1;
                end
                ar_fire = ARVALID && ARREADY;
                if (ar_fire) begin
                    ar_addr_hold = ARADDR;
                    ar_log.push_back(ARADDR);
                    len_log.push_back(ARLEN);
                end
                if (slv_active) begin
                    RVALID = 1'b1;
                    RDATA  = override_en ? override_data : ddr_word(slv_addr + 32'(slv_beat * 8));
                    RLAST  = (slv_beat == cur_rlast_beat);
                    RRESP  = (slv_beat == cur_rresp_beat) ? 2'b10 : 2'b00;
                end else begin
                    RVALID = 1'b0;
                    RLAST  = 1'b0;
                    RRESP  = 2'b00;
                end
                r_fire = RVALID && RREADY;
            end
        end
    end

    // Pixel sink: a handshake is decided by values stable at the falling edge.
    initial begin : pixel_sink
        forever begin
            @(negedge clk_100Mhz);
            if (rst_n === 1'b1) begin
                if (pixel_valid && pixel_ready) begin
                    if (check_pixels)
                        checkOutput($sformatf("pixel[%0d]", pix_idx), 64'(pixel_data), 64'(exp_pixel(pix_base, pix_idx)));
                    pix_idx++;
                end
                if (reader_done) done_count++;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n           = 1'b0;
        frame_start     = 1'b0;
        FRAME_BASE_ADDR = '0;
        pixel_ready     = 1'b0;
        toggle_rvalid   = 1'b1;

        // Reset with RVALID toggling
        $display("[TB] reset test");
        repeat (5) tick();
        checkOutput("rst_state",       64'(state),       64'd0);
        checkOutput("rst_arvalid",     64'(ARVALID),     64'd0);
        checkOutput("rst_rready",      64'(RREADY),      64'd0);
        checkOutput("rst_araddr",      64'(ARADDR),      64'd0);
        checkOutput("rst_reader_done", 64'(reader_done), 64'd0);
        checkOutput("rst_rd_error",    64'(rd_error),    64'd0);
        checkOutput("rst_pixel_valid", 64'(pixel_valid), 64'd0);
        checkOutput("const_arlen",     64'(ARLEN),       64'd79);
        checkOutput("const_arsize",    64'(ARSIZE),      64'd3);
        checkOutput("const_arburst",   64'(ARBURST),     64'd1);
        checkOutput("const_arcache",   64'(ARCACHE),     64'd3);
        checkOutput("const_arprot",    64'(ARPROT),      64'd0);
        rst_n = 1'b1;
        toggle_rvalid = 1'b0;
        repeat (5) tick();
        checkOutput("idle_no_ar",    64'(ar_log.size()), 64'd0);
        checkOutput("idle_state",    64'(state),         64'd0);

        // Pixel order within a word and stall hold
        $display("[TB] pixel order test");
        override_en   = 1'b1;
        override_data = 64'h1111_2222_3333_4444;
        order_exp[0] = 16'h2222;
        order_exp[1] = 16'h3333;
        order_exp[2] = 16'h4444;
        order_exp[3] = 16'h1111;
        ar_log.delete();
        len_log.delete();
        applyStimulus(32'h2000_0000);
        for (int i = 0; i < 50 && !pixel_valid; i++) tick();
        checkOutput("order_valid_timeout", 64'(pixel_valid), 64'd1);
        checkOutput("order_lane0", 64'(pixel_data), 64'h1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("order_stall%0d", i), 64'(pixel_data), 64'h1111);
        end
        for (int k = 0; k < 4; k++) begin
            pixel_ready = 1'b1;
            tick();
            pixel_ready = 1'b0;
            checkOutput($sformatf("order_step%0d", k), 64'(pixel_data), 64'(order_exp[k]));
        end
        repeat (2) tick();
        checkOutput("order_hold_after", 64'(pixel_data), 64'h1111);
        doReset();
        override_en = 1'b0;
        checkOutput("order_reset_empty", 64'(pixel_valid), 64'd0);

        // Backpressure: three bursts fill the FIFO to 240, the fourth waits for room
        $display("[TB] backpressure test");
        ar_log.delete();
        len_log.delete();
        pix_base     = 32'h3000_0000;
        pix_idx      = 0;
        check_pixels = 1'b1;
        applyStimulus(32'h3000_0000);
        repeat (400) tick();
        checkOutput("bp_ar_count_held", 64'(ar_log.size()), 64'd3);
        checkOutput("bp_state_idle",    64'(state),         64'd0);
        checkOutput("bp_pixel_valid",   64'(pixel_valid),   64'd1);
        pixel_ready = 1'b1;
        for (int i = 0; i < 400 && ar_log.size() < 4; i++) tick();
        checkOutput("bp_fourth_ar", 64'(ar_log.size()), 64'd4);
        checkOutput("bp_fourth_addr", 64'((ar_log.size() > 3) ? ar_log[3] : 32'hFFFF_FFFF), 64'h3000_0780);
        for (int i = 0; i < 2000 && pix_idx < 4 * PIX_BURST; i++) tick();
        checkOutput("bp_pixels_timeout", 64'(pix_idx >= 4 * PIX_BURST), 64'd1);
        doReset();

        // Full frame, everything ready
        $display("[TB] full frame test");
        ar_log.delete();
        len_log.delete();
        done_count = 0;
        pix_base   = 32'h1000_0000;
        pix_idx    = 0;
        applyStimulus(32'h1000_0000);
        for (int i = 0; i < 12000 && pix_idx < FRAME_PIX; i++) tick();
        checkOutput("frame_pixels_timeout", 64'(pix_idx >= FRAME_PIX), 64'd1);
        repeat (5) tick();
        checkOutput("frame_ar_count", 64'(ar_log.size()), 64'(TB_BURSTS));
        for (int k = 0; k < TB_BURSTS; k++) begin
            checkOutput($sformatf("frame_araddr[%0d]", k),
                        64'((k < ar_log.size()) ? ar_log[k] : 32'hFFFF_FFFF),
                        64'(32'h1000_0000 + 32'(k * 640)));
            checkOutput($sformatf("frame_arlen[%0d]", k),
                        64'((k < len_log.size()) ? len_log[k] : 8'hFF), 64'd79);
        end
        checkOutput("frame_last_addr", 64'((ar_log.size() > 23) ? ar_log[23] : 32'hFFFF_FFFF), 64'h1000_3980);
        checkOutput("frame_done_once", 64'(done_count),   64'd1);
        checkOutput("frame_no_error",  64'(rd_error),     64'd0);
        checkOutput("frame_end_state", 64'(state),        64'd0);
        checkOutput("frame_drained",   64'(pixel_valid),  64'd0);
        checkOutput("frame_done_low",  64'(reader_done),  64'd0);

        // RRESP error on beat 5 of the first burst; a mid-frame edge is ignored
        $display("[TB] rresp error test");
        ar_log.delete();
        len_log.delete();
        done_count     = 0;
        pix_base       = 32'h4000_0000;
        pix_idx        = 0;
        arm_rresp_beat = 5;
        applyStimulus(32'h4000_0000);
        checkOutput("rresp_err_clear_on_start", 64'(rd_error), 64'd0);
        for (int i = 0; i < 300 && ar_log.size() < 2; i++) tick();
        checkOutput("rresp_second_ar", 64'(ar_log.size() >= 2), 64'd1);
        checkOutput("rresp_err_set", 64'(rd_error), 64'd1);
        applyStimulus(32'h5000_0000);
        for (int i = 0; i < 12000 && pix_idx < FRAME_PIX; i++) tick();
        checkOutput("rresp_pixels_timeout", 64'(pix_idx >= FRAME_PIX), 64'd1);
        repeat (5) tick();
        checkOutput("rresp_ar_count", 64'(ar_log.size()), 64'(TB_BURSTS));
        checkOutput("rresp_addr1",    64'((ar_log.size() > 1)  ? ar_log[1]  : 32'hFFFF_FFFF), 64'h4000_0280);
        checkOutput("rresp_addr_last", 64'((ar_log.size() > 23) ? ar_log[23] : 32'hFFFF_FFFF), 64'h4000_3980);
        checkOutput("rresp_done_once", 64'(done_count), 64'd1);
        checkOutput("rresp_err_sticky", 64'(rd_error),  64'd1);

        // Next accepted start clears the flag; early RLAST on beat 40 sets it again
        $display("[TB] rlast error test");
        ar_log.delete();
        len_log.delete();
        pix_base       = 32'h4800_0000;
        pix_idx        = 0;
        arm_rlast_beat = 40;
        applyStimulus(32'h4800_0000);
        checkOutput("rlast_err_cleared", 64'(rd_error), 64'd0);
        for (int i = 0; i < 300 && ar_log.size() < 2; i++) tick();
        checkOutput("rlast_second_ar", 64'(ar_log.size() >= 2), 64'd1);
        checkOutput("rlast_err_set",   64'(rd_error), 64'd1);
        checkOutput("rlast_addr1", 64'((ar_log.size() > 1) ? ar_log[1] : 32'hFFFF_FFFF), 64'h4800_0280);
        doReset();
        checkOutput("rlast_reset_clears", 64'(rd_error), 64'd0);

        // AR stall then reset in the middle of a burst
        $display("[TB] ar stall and mid-burst reset test");
        ar_log.delete();
        len_log.delete();
        pix_base      = 32'h6000_0000;
        pix_idx       = 0;
        ar_stall_left = 10;
        applyStimulus(32'h6000_0000);
        for (int i = 0; i < 20 && !ARVALID; i++) tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stall_arvalid%0d", i), 64'(ARVALID), 64'd1);
            checkOutput($sformatf("stall_araddr%0d", i),  64'(ARADDR),  64'h6000_0000);
            tick();
        end
        for (int i = 0; i < 20 && ar_log.size() < 1; i++) tick();
        checkOutput("stall_ar_done", 64'(ar_log.size()), 64'd1);
        for (int i = 0; i < 100 && !(slv_active && slv_beat >= 30); i++) tick();
        checkOutput("midburst_reached_beat30", 64'(slv_active && slv_beat >= 30), 64'd1);
        doReset();
        checkOutput("midburst_state",   64'(state),       64'd0);
        checkOutput("midburst_empty",   64'(pixel_valid), 64'd0);
        checkOutput("midburst_arvalid", 64'(ARVALID),     64'd0);
        checkOutput("midburst_rready",  64'(RREADY),      64'd0);
        ar_log.delete();
        len_log.delete();
        applyStimulus(32'h6000_0000);
        for (int i = 0; i < 20 && ar_log.size() < 1; i++) tick();
        checkOutput("restart_addr", 64'((ar_log.size() > 0) ? ar_log[0] : 32'hFFFF_FFFF), 64'h6000_0000);
        for (int i = 0; i < 400 && pix_idx < 160; i++) tick();
        checkOutput("restart_pixels_timeout", 64'(pix_idx >= 160), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
